imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered immediate-generation stage between instruction fetch/decode and the execute-side operand muxes.
- Decodes every RV32I/RV64I immediate format (I, shift, S, B, U, J) to XLEN bits and classifies the format.
- Flags opcodes it does not recognise.
- Uses a valid/ready pipeline with an optional skid buffer and a synchronous flush, so branch redirects can kill in-flight instructions.

Parameters:
- XLEN, 32, datapath width (32 or 64); sets immediate width and shamt width (5 or 6 bits).
- SKID_EN, 1, 1 = two-entry skid buffer (in_ready_o registered), 0 = single register (in_ready_o combinational).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-low reset.
- flush_i  in  1  kill all buffered entries.
- in_valid_i  in  1  instr_i/pc_i valid.
- in_ready_o  out  1  stage can accept.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  instruction PC.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  consumer accepts.
- imm_o  out  XLEN  decoded immediate.
- fmt_o  out  3  format code.
- illegal_o  out  1  unrecognised opcode.
- pc_o  out  XLEN  PC of the output entry.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - out_valid_o=0; imm_o, pc_o, fmt_o and illegal_o are 0.
  - Skid entry is invalid; in_ready_o=1 from the first cycle after reset.
  - Reset mid-transfer drops all entries. No output handshake occurs in the reset cycle.
- Transfers:
  - Input transfer happens on in_valid_i & in_ready_o.
  - Output transfer happens on out_valid_o & out_ready_i.
  - Latency is 1 cycle from input transfer to out_valid_o when the stage is empty.
  - Order is strictly preserved.
- Decode is combinational on instr_i and is registered with the entry. The format code drives fmt_o:
  - 0010011 with funct3 001/101 -> SH (6). imm = zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. Funct7 bits are never in imm.
  - 0010011 (other funct3), 0000011, 1100111 -> I (1). imm = sext(instr[31:20]).
  - 0100011 -> S (2). imm = sext({instr[31:25],instr[11:7]}).
  - 1100011 -> B (3). imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - 0110111 and 0010111 -> U (4). imm = sext32({instr[31:12],12'b0}) to XLEN.
  - 1101111 -> J (5). imm = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - 0110011, 0001111, 1110011 -> NONE (0), imm=0, illegal_o=0.
  - Any other opcode -> NONE (0), imm=0, illegal_o=1.
  - Codes 7 and any code not listed above are never produced.
- SKID_EN=1 state machine (EMPTY, ONE, TWO):
  - EMPTY: input transfer -> ONE.
  - ONE, input without output -> TWO (new entry goes to skid).
  - ONE, output without input -> EMPTY.
  - ONE, both -> ONE (main reloads).
  - TWO: in_ready_o=0. An output transfer moves skid to main -> ONE.
  - in_ready_o = (state != TWO), driven from a register.
- SKID_EN=0:
  - Single entry; in_ready_o = !out_valid_o | out_ready_i.
  - Simultaneous in and out transfers reload the register (full throughput).
- Flush:
  - flush_i=1 at an edge -> state EMPTY and out_valid_o=0 next cycle.
  - Any input presented in the same cycle is discarded, even if in_ready_o=1.
  - Flush takes priority over all transfers. Reset takes priority over flush.
- Output stability: while out_valid_o=1 and out_ready_i=0, imm_o, fmt_o, illegal_o and pc_o hold constant.

Decomposition:
- Shared package imm_gen_pkg:
  - fmt enum: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SH=6.
  - Opcode constants: OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, MISC_MEM, SYSTEM.
- One sub-module imm_decode: combinational, parametrised by XLEN. Inputs instr; outputs imm, fmt, illegal.
- imm_gen_stage itself holds the skid control and the registers only.

Test Plan:
- XLEN=32, empty stage, out_ready_i=1, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, illegal_o=0, pc_o=pushed pc.
- Push 0x4032D293 (srai x5,x5,3) -> imm_o=0x00000003, fmt_o=6. Then push 0xFE000EE3 (beq -4) -> imm_o=0xFFFFFFFC, fmt_o=3.
- Push 0x123450B7 (lui) -> imm_o=0x12345000, fmt_o=4. Push 0x0080006F (jal +8) -> imm_o=0x00000008, fmt_o=5. With XLEN=64, push 0x800000B7 -> imm_o=0xFFFFFFFF80000000.
- SKID_EN=1, out_ready_i=0, offer A, B, C back-to-back:
  - A and B are accepted; in_ready_o=0 after B; C is held.
  - With out_ready_i=1: A, B, C emerge in order on consecutive cycles, and outputs are stable while stalled.
- Two entries buffered, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, the flushed-cycle input never appears.
- Push 0x0000007F -> illegal_o=1, imm_o=0, fmt_o=0.
- Assert rst_i=0 with TWO entries held -> out_valid_o=0 and all data outputs 0 next cycle.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
// Format codes match the fmt_o encoding seen by the execute-side muxes.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  // RV64 shifts carry a 6-bit shamt; RV32 only 5.
  function automatic int shamt_width(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: sign-extended immediate,
// format class and an illegal flag for opcodes outside the known set.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  localparam int SHW = shamt_width(XLEN);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift immediates drop funct7 entirely; only the shamt is passed on.
          fmt_o            = FMT_SH;
          imm_o[SHW-1:0]   = instr_i[20 +: SHW];
        end else begin
          fmt_o = FMT_I;
          imm_o = XLEN'($signed(instr_i[31:20]));
        end
      end
      LOAD, JALR: begin
        fmt_o = FMT_I;
        imm_o = XLEN'($signed(instr_i[31:20]));
      end
      STORE: begin
        fmt_o = FMT_S;
        imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      end
      BRANCH: begin
        fmt_o = FMT_B;
        imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0}));
      end
      LUI, AUIPC: begin
        fmt_o = FMT_U;
        imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      JAL: begin
        fmt_o = FMT_J;
        imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                               instr_i[30:21], 1'b0}));
      end
      OP, MISC_MEM, SYSTEM: begin
        fmt_o = FMT_NONE;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready handshakes,
// optional two-entry skid buffer and a synchronous flush for redirects.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr_i),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;
  fmt_e            fmt_q, fmt_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] sk_imm_q, sk_imm_d, sk_pc_q, sk_pc_d;
  fmt_e            sk_fmt_q, sk_fmt_d;
  logic            sk_ill_q, sk_ill_d;
  logic            in_fire, out_fire;

  // The reset cycle never presents a valid entry, so no handshake can occur in it.
  assign out_valid_o = (state_q != ST_EMPTY) & rst_i;
  assign in_ready_o  = SKID_EN ? in_ready_q : ((state_q == ST_EMPTY) | out_ready_i);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  assign imm_o     = imm_q;
  assign fmt_o     = fmt_q;
  assign illegal_o = ill_q;
  assign pc_o      = pc_q;

  always_comb begin
    state_d  = state_q;
    imm_d    = imm_q;
    fmt_d    = fmt_q;
    ill_d    = ill_q;
    pc_d     = pc_q;
    sk_imm_d = sk_imm_q;
    sk_fmt_d = sk_fmt_q;
    sk_ill_d = sk_ill_q;
    sk_pc_d  = sk_pc_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            imm_d = dec_imm; fmt_d = dec_fmt; ill_d = dec_ill; pc_d = pc_i;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            imm_d = dec_imm; fmt_d = dec_fmt; ill_d = dec_ill; pc_d = pc_i;
          end else if (in_fire) begin
            // Only reachable with the skid enabled: without it in_fire implies out_fire here.
            state_d  = ST_TWO;
            sk_imm_d = dec_imm; sk_fmt_d = dec_fmt; sk_ill_d = dec_ill; sk_pc_d = pc_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            imm_d = sk_imm_q; fmt_d = sk_fmt_q; ill_d = sk_ill_q; pc_d = sk_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      imm_q      <= '0;
      fmt_q      <= FMT_NONE;
      ill_q      <= 1'b0;
      pc_q       <= '0;
      sk_imm_q   <= '0;
      sk_fmt_q   <= FMT_NONE;
      sk_ill_q   <= 1'b0;
      sk_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      imm_q      <= imm_d;
      fmt_q      <= fmt_d;
      ill_q      <= ill_d;
      pc_q       <= pc_d;
      sk_imm_q   <= sk_imm_d;
      sk_fmt_q   <= sk_fmt_d;
      sk_ill_q   <= sk_ill_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: XLEN=32 skid-buffered instance plus an XLEN=64 single-register instance.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr, pc;
  logic        in_ready, out_valid, ill;
  logic [31:0] imm, pc_out;
  logic [2:0]  fmt;

  logic        flush64, in_valid64, out_ready64;
  logic [31:0] instr64;
  logic [63:0] pc64;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64, pc_out64;
  logic [2:0]  fmt64;

  int total = 0;
  int bad   = 0;

  imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm), .fmt_o(fmt), .illegal_o(ill), .pc_o(pc_out)
  );

  imm_gen_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush64),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64),
    .instr_i(instr64), .pc_i(pc64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64),
    .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64), .pc_o(pc_out64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] ins, input logic [31:0] p);
    in_valid = 1'b1; instr = ins; pc = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push64(input logic [31:0] ins, input logic [63:0] p);
    in_valid64 = 1'b1; instr64 = ins; pc64 = p;
    tick();
    in_valid64 = 1'b0;
  endtask

  task automatic expect32(input string tag, input logic [31:0] e_imm, input logic [2:0] e_fmt,
                          input logic e_ill, input logic [31:0] e_pc);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".imm"},   64'(imm),       64'(e_imm));
    check({tag, ".fmt"},   64'(fmt),       64'(e_fmt));
    check({tag, ".ill"},   64'(ill),       64'(e_ill));
    check({tag, ".pc"},    64'(pc_out),    64'(e_pc));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; pc = '0;
    flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1; instr64 = '0; pc64 = '0;
    tick();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.imm",   64'(imm),       64'd0);
    check("rst.fmt",   64'(fmt),       64'd0);
    check("rst.ill",   64'(ill),       64'd0);
    check("rst.pc",    64'(pc_out),    64'd0);
    check("rst64.valid", 64'(out_valid64), 64'd0);
    rst = 1'b1;
    tick();
    check("post_rst.ready", 64'(in_ready), 64'd1);

    // Decode coverage, streaming with the consumer always ready.
    push32(32'hFFF00093, 32'h0000_0100); expect32("addi",  32'hFFFFFFFF, 3'd1, 1'b0, 32'h100);
    push32(32'h4032D293, 32'h0000_0104); expect32("srai",  32'h00000003, 3'd6, 1'b0, 32'h104);
    push32(32'hFE000EE3, 32'h0000_0108); expect32("beq",   32'hFFFFFFFC, 3'd3, 1'b0, 32'h108);
    push32(32'h123450B7, 32'h0000_010C); expect32("lui",   32'h12345000, 3'd4, 1'b0, 32'h10C);
    push32(32'h0080006F, 32'h0000_0110); expect32("jal",   32'h00000008, 3'd5, 1'b0, 32'h110);
    push32(32'hFE112E23, 32'h0000_0114); expect32("sw",    32'hFFFFFFFC, 3'd2, 1'b0, 32'h114);
    push32(32'h02009093, 32'h0000_0118); expect32("slli25", 32'h00000000, 3'd6, 1'b0, 32'h118);
    push32(32'h00000033, 32'h0000_011C); expect32("op",    32'h00000000, 3'd0, 1'b0, 32'h11C);
    push32(32'h0000007F, 32'h0000_0120); expect32("illeg", 32'h00000000, 3'd0, 1'b1, 32'h120);
    tick();
    check("drain.valid", 64'(out_valid), 64'd0);

    // Back-pressure: A and B fill main+skid, C is held off.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF00093; pc = 32'h200;
    tick();
    check("skid.ready_after_A", 64'(in_ready), 64'd1);
    instr = 32'h123450B7; pc = 32'h204;
    tick();
    check("skid.ready_after_B", 64'(in_ready), 64'd0);
    expect32("skid.A", 32'hFFFFFFFF, 3'd1, 1'b0, 32'h200);
    instr = 32'h0080006F; pc = 32'h208;
    tick();
    check("skid.C_held", 64'(in_ready), 64'd0);
    expect32("skid.A_stable", 32'hFFFFFFFF, 3'd1, 1'b0, 32'h200);
    out_ready = 1'b1;
    tick();
    expect32("skid.B", 32'h12345000, 3'd4, 1'b0, 32'h204);
    tick();
    in_valid = 1'b0;
    expect32("skid.C", 32'h00000008, 3'd5, 1'b0, 32'h208);
    tick();
    check("skid.empty", 64'(out_valid), 64'd0);

    // Flush with two entries buffered and an input offered.
    out_ready = 1'b0;
    push32(32'hFFF00093, 32'h300);
    push32(32'h123450B7, 32'h304);
    in_valid = 1'b1; instr = 32'h0080006F; pc = 32'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2.valid", 64'(out_valid), 64'd0);
    check("flush2.ready", 64'(in_ready),  64'd1);
    tick();
    check("flush2.no_ghost", 64'(out_valid), 64'd0);

    // Flush with one entry while in_ready is high: the offered input is still dropped.
    push32(32'hFFF00093, 32'h400);
    check("flush1.ready_pre", 64'(in_ready), 64'd1);
    in_valid = 1'b1; instr = 32'h123450B7; pc = 32'h404; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1.valid", 64'(out_valid), 64'd0);
    tick();
    check("flush1.no_ghost", 64'(out_valid), 64'd0);

    // Reset with two entries held.
    push32(32'hFFF00093, 32'h500);
    push32(32'h123450B7, 32'h504);
    check("rst2.full", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("rst2.valid", 64'(out_valid), 64'd0);
    check("rst2.imm",   64'(imm),       64'd0);
    check("rst2.fmt",   64'(fmt),       64'd0);
    check("rst2.ill",   64'(ill),       64'd0);
    check("rst2.pc",    64'(pc_out),    64'd0);
    rst = 1'b1;
    tick();
    check("rst2.ready", 64'(in_ready),  64'd1);
    check("rst2.empty", 64'(out_valid), 64'd0);

    // XLEN=64, single-register variant.
    push64(32'h800000B7, 64'h1_0000_0000);
    check("x64.lui.valid", 64'(out_valid64), 64'd1);
    check("x64.lui.imm",   imm64,            64'hFFFFFFFF80000000);
    check("x64.lui.fmt",   64'(fmt64),       64'd4);
    check("x64.lui.pc",    pc_out64,         64'h1_0000_0000);
    push64(32'h02009093, 64'h1_0000_0004);
    check("x64.slli.imm",  imm64,            64'h20);
    check("x64.slli.fmt",  64'(fmt64),       64'd6);
    out_ready64 = 1'b0;
    #1;
    check("x64.stall.ready", 64'(in_ready64), 64'd0);
    in_valid64 = 1'b1; instr64 = 32'hFFF00093; pc64 = 64'h1_0000_0008;
    tick();
    check("x64.stall.imm", imm64,    64'h20);
    check("x64.stall.pc",  pc_out64, 64'h1_0000_0004);
    out_ready64 = 1'b1;
    #1;
    check("x64.comb_ready", 64'(in_ready64), 64'd1);
    tick();
    in_valid64 = 1'b0;
    check("x64.reload.imm", imm64,    64'hFFFFFFFFFFFFFFFF);
    check("x64.reload.pc",  pc_out64, 64'h1_0000_0008);
    tick();
    check("x64.empty", 64'(out_valid64), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
